// File: rtl/dma_priority_arbiter_if.sv
// Hold/grant handshake between the DMA priority arbiter, the CPU hold logic
// and the transfer FSM.
interface dma_priority_arbiter_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
);
  logic           hrq;
  logic           hlda;
  logic           svcDone;
  logic           grantValid;
  logic [CHW-1:0] grantCh;
  logic [NCH-1:0] dack;

  // master: the arbiter; slave: CPU hold logic plus transfer FSM
  modport master (
    output hrq,
    output grantValid,
    output grantCh,
    output dack,
    input  hlda,
    input  svcDone
  );

  modport slave (
    input  hrq,
    input  grantValid,
    input  grantCh,
    input  dack,
    output hlda,
    output svcDone
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel priority resolver and bus-request stage: synchronises DREQ,
// resolves fixed/rotating priority, raises HRQ and holds one grant until end of service.
module dma_priority_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NCH-1:0]        DREQ,
  input  logic [7:0]            commandReg,
  input  logic [7:0]            requestReg,
  input  logic [7:0]            maskReg,
  dma_priority_arbiter_if.master bus,
  output logic [CHW-1:0]        prioTop
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGrant
  } arbStateT;

  arbStateT       state;
  logic [NCH-1:0] syncMeta;
  logic [NCH-1:0] syncReq;
  logic           hrqQ;
  logic           grantValidQ;
  logic [CHW-1:0] grantChQ;
  logic [CHW-1:0] prioTopQ;

  logic           enable;
  logic           rotate;
  logic [NCH-1:0] level;
  logic [NCH-1:0] effReq;
  logic           anyReq;
  logic [CHW-1:0] winner;
  logic [CHW-1:0] cand;
  logic           found;
  logic [NCH-1:0] grantOneHot;

  logic unusedCfgBits;
  assign unusedCfgBits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                           requestReg[7:NCH], maskReg[7:NCH]};

  assign enable = ~commandReg[2];
  assign rotate = commandReg[4];
  assign level  = syncReq ^ {NCH{commandReg[6]}};
  // Software requests bypass the mask.
  assign effReq = (level & ~maskReg[NCH-1:0]) | requestReg[NCH-1:0];
  assign anyReq = |effReq;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      syncMeta <= '0;
      syncReq  <= '0;
    end else begin
      syncMeta <= DREQ;
      syncReq  <= syncMeta;
    end
  end

  // Scan upward from prioTop, wrapping modulo NCH; first requester wins.
  always_comb begin
    winner = prioTopQ;
    found  = 1'b0;
    cand   = prioTopQ;
    for (int i = 0; i < NCH; i++) begin
      cand = prioTopQ + CHW'(i);
      if (!found && effReq[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= StIdle;
      hrqQ        <= 1'b0;
      grantValidQ <= 1'b0;
      grantChQ    <= '0;
      prioTopQ    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (enable && anyReq) begin
            state <= StReq;
            hrqQ  <= 1'b1;
          end
        end
        StReq: begin
          if (bus.hlda) begin
            if (anyReq) begin
              state       <= StGrant;
              grantChQ    <= winner;
              grantValidQ <= 1'b1;
            end else begin
              state <= StIdle;
              hrqQ  <= 1'b0;
            end
          end else if (!anyReq || !enable) begin
            state <= StIdle;
            hrqQ  <= 1'b0;
          end
        end
        StGrant: begin
          // Grant ignores DREQ, mask and enable; only svcDone or loss of HLDA end it.
          if (bus.svcDone) begin
            state       <= StIdle;
            hrqQ        <= 1'b0;
            grantValidQ <= 1'b0;
            if (rotate) begin
              prioTopQ <= grantChQ + CHW'(1);
            end
          end else if (!bus.hlda) begin
            state       <= StIdle;
            hrqQ        <= 1'b0;
            grantValidQ <= 1'b0;
          end
        end
        default: begin
          state       <= StIdle;
          hrqQ        <= 1'b0;
          grantValidQ <= 1'b0;
        end
      endcase
      if (!rotate) begin
        prioTopQ <= '0;
      end
    end
  end

  assign grantOneHot = (NCH'(1) << grantChQ) & {NCH{grantValidQ}};

  assign bus.hrq        = hrqQ;
  assign bus.grantValid = grantValidQ;
  assign bus.grantCh    = grantChQ;
  assign bus.dack       = commandReg[7] ? grantOneHot : ~grantOneHot;
  assign prioTop        = prioTopQ;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a priority reference model.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [7:0] requestReg;
  logic [7:0] maskReg;
  logic [1:0] prioTop;

  dma_priority_arbiter_if #(.NCH(4), .CHW(2)) bus ();

  dma_priority_arbiter #(.NCH(4), .CHW(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .commandReg (commandReg),
    .requestReg (requestReg),
    .maskReg    (maskReg),
    .bus        (bus),
    .prioTop    (prioTop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] mask;
    logic [7:0] req;
    logic [3:0] pins;
    int         lat;
    logic [1:0] ch;
    logic [3:0] dack;
    logic [1:0] prio;
  } vecT;

  vecT vecs[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference priority: first requester scanning upward from top, modulo 4.
  function automatic int refWinner(input logic [3:0] eff, input int top);
    for (int i = 0; i < 4; i++) begin
      if (eff[(top + i) % 4]) return (top + i) % 4;
    end
    return 0;
  endfunction

  task automatic settle(input logic [7:0] cmd);
    commandReg = cmd | 8'h04;
    requestReg = 8'h00;
    maskReg    = 8'h00;
    DREQ       = cmd[6] ? 4'hF : 4'h0;
    bus.hlda    = 1'b0;
    bus.svcDone = 1'b0;
    repeat (5) tick();
  endtask

  task automatic waitHrq(input string nm, input int expLat);
    int lat;
    lat = 0;
    while (!bus.hrq && lat < 10) begin
      tick();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(expLat));
  endtask

  // One full request/grant/service transaction; expLat==0 means no HRQ expected.
  task automatic runTxn(input string nm, input logic [7:0] cmd, input logic [7:0] mask,
                        input logic [7:0] req, input logic [3:0] pins, input int expLat,
                        input logic [1:0] expCh, input logic [3:0] expDack,
                        input logic [1:0] expPrio);
    settle(cmd);
    maskReg = mask;
    check({nm, " setup hrq"}, 32'(bus.hrq), 32'd0);
    commandReg = cmd;
    requestReg = req;
    DREQ       = pins;
    if (expLat == 0) begin
      repeat (6) tick();
      check({nm, " no hrq"}, 32'(bus.hrq), 32'd0);
    end else begin
      waitHrq({nm, " hrq"}, expLat);
      repeat ($urandom_range(4, 2)) tick();
      bus.hlda = 1'b1;
      tick();
      check({nm, " grantValid"}, 32'(bus.grantValid), 32'd1);
      check({nm, " grantCh"}, 32'(bus.grantCh), 32'(expCh));
      check({nm, " dack"}, 32'(bus.dack), 32'(expDack));
      repeat ($urandom_range(3, 0)) tick();
      bus.svcDone = 1'b1;
      tick();
      bus.svcDone = 1'b0;
      bus.hlda    = 1'b0;
      check({nm, " post hrq"}, 32'(bus.hrq), 32'd0);
      check({nm, " post grantValid"}, 32'(bus.grantValid), 32'd0);
      check({nm, " post dack"}, 32'(bus.dack), cmd[7] ? 32'h0 : 32'hF);
      check({nm, " prioTop"}, 32'(prioTop), 32'(expPrio));
    end
    requestReg = 8'h00;
    DREQ       = cmd[6] ? 4'hF : 4'h0;
  endtask

  logic [7:0] rCmd, rMask, rReq;
  logic [3:0] rPins, rLevel, rEff, rOh;
  logic [1:0] rCh, rNewPrio;
  int         rLat, rWin, mPrio, dropLat;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 4'b1010, 3, 2'd1, 4'b1101, 2'd0};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 4'b1010, 3, 2'd1, 4'b1101, 2'd0};
    vecs[2] = '{8'h00, 8'h0F, 8'h00, 4'b1111, 0, 2'd0, 4'b1111, 2'd0};
    vecs[3] = '{8'h00, 8'h0F, 8'h04, 4'b1111, 1, 2'd2, 4'b1011, 2'd0};
    vecs[4] = '{8'hC0, 8'h00, 8'h00, 4'b0111, 3, 2'd3, 4'b1000, 2'd0};
    vecs[5] = '{8'h80, 8'h02, 8'h00, 4'b0110, 3, 2'd2, 4'b0100, 2'd0};
    vecs[6] = '{8'h00, 8'h00, 8'h08, 4'b0001, 1, 2'd0, 4'b1110, 2'd0};

    RESET       = 1'b0;
    DREQ        = 4'h0;
    commandReg  = 8'h00;
    requestReg  = 8'h00;
    maskReg     = 8'h00;
    bus.hlda    = 1'b0;
    bus.svcDone = 1'b0;
    #3;
    check("reset hrq", 32'(bus.hrq), 32'd0);
    check("reset grantValid", 32'(bus.grantValid), 32'd0);
    check("reset grantCh", 32'(bus.grantCh), 32'd0);
    check("reset prioTop", 32'(prioTop), 32'd0);
    check("reset dack", 32'(bus.dack), 32'hF);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      runTxn($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].mask, vecs[v].req, vecs[v].pins,
             vecs[v].lat, vecs[v].ch, vecs[v].dack, vecs[v].prio);
    end

    // Rotating priority, all channels requesting: grants walk 0,1,2,3 and prioTop wraps.
    for (int r = 0; r < 4; r++) begin
      runTxn($sformatf("rot%0d", r), 8'h10, 8'h00, 8'h00, 4'hF, 3, 2'(r), ~(4'b0001 << r),
             2'((r + 1) % 4));
    end

    mPrio = 0;
    for (int t = 0; t < 30; t++) begin
      rCmd    = 8'h00;
      rCmd[7] = 1'($urandom_range(1, 0));
      rCmd[6] = 1'($urandom_range(1, 0));
      rCmd[4] = 1'($urandom_range(1, 0));
      rMask   = 8'($urandom);
      rReq    = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
      rPins   = 4'($urandom);
      rLevel  = rPins ^ {4{rCmd[6]}};
      rEff    = (rLevel & ~rMask[3:0]) | rReq[3:0];
      if (rEff == 4'h0) begin
        rLat = 0;
        rCh  = 2'd0;
        rOh  = 4'h0;
      end else begin
        rLat = (rReq[3:0] != 4'h0) ? 1 : 3;
        rWin = refWinner(rEff, rCmd[4] ? mPrio : 0);
        rCh  = 2'(rWin);
        rOh  = 4'b0001 << rCh;
      end
      rNewPrio = rCmd[4] ? ((rEff == 4'h0) ? 2'(mPrio) : 2'((rWin + 1) % 4)) : 2'd0;
      runTxn($sformatf("rnd%0d", t), rCmd, rMask, rReq, rPins, rLat, rCh,
             rCmd[7] ? rOh : ~rOh, rNewPrio);
      mPrio = int'(rNewPrio);
    end

    // Request withdrawn before HLDA: back to idle without a grant.
    settle(8'h00);
    commandReg = 8'h00;
    DREQ       = 4'b0001;
    waitHrq("withdraw hrq", 3);
    DREQ    = 4'b0000;
    dropLat = 0;
    while (bus.hrq && dropLat < 10) begin
      tick();
      dropLat++;
    end
    check("withdraw drop latency", 32'(dropLat), 32'd3);
    check("withdraw grantValid", 32'(bus.grantValid), 32'd0);

    // Grant held through DREQ drop, full mask and disable; HLDA loss aborts without rotation.
    runTxn("abort pre", 8'h10, 8'h00, 8'h00, 4'b0010, 3, 2'd1, 4'b1101, 2'd2);
    settle(8'h10);
    commandReg = 8'h10;
    DREQ       = 4'b1000;
    waitHrq("abort hrq", 3);
    repeat (2) tick();
    bus.hlda = 1'b1;
    tick();
    check("abort grantCh", 32'(bus.grantCh), 32'd3);
    DREQ       = 4'b0000;
    maskReg    = 8'h0F;
    commandReg = 8'h14;
    repeat (4) tick();
    check("hold grantValid", 32'(bus.grantValid), 32'd1);
    check("hold grantCh", 32'(bus.grantCh), 32'd3);
    check("hold hrq", 32'(bus.hrq), 32'd1);
    check("hold dack", 32'(bus.dack), 32'b0111);
    bus.hlda = 1'b0;
    tick();
    check("abort grantValid", 32'(bus.grantValid), 32'd0);
    check("abort hrq", 32'(bus.hrq), 32'd0);
    check("abort prioTop", 32'(prioTop), 32'd2);
    maskReg     = 8'h00;
    commandReg  = 8'h10;
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
    tick();
    check("stray svcDone prioTop", 32'(prioTop), 32'd2);
    check("stray svcDone hrq", 32'(bus.hrq), 32'd0);

    // Rotating -> fixed mid-grant: prioTop clears next cycle, grant untouched.
    DREQ = 4'b1001;
    waitHrq("switch hrq", 3);
    repeat (2) tick();
    bus.hlda = 1'b1;
    tick();
    check("switch grantCh", 32'(bus.grantCh), 32'd3);
    commandReg = 8'h00;
    tick();
    check("switch prioTop", 32'(prioTop), 32'd0);
    check("switch grantValid", 32'(bus.grantValid), 32'd1);
    check("switch grantCh held", 32'(bus.grantCh), 32'd3);
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
    bus.hlda    = 1'b0;
    check("switch post prioTop", 32'(prioTop), 32'd0);
    check("switch post grantValid", 32'(bus.grantValid), 32'd0);

    // Asynchronous reset in the middle of a grant.
    runTxn("rst pre", 8'h10, 8'h00, 8'h00, 4'b0001, 3, 2'd0, 4'b1110, 2'd1);
    settle(8'h10);
    commandReg = 8'h10;
    DREQ       = 4'b0100;
    waitHrq("rst hrq", 3);
    repeat (2) tick();
    bus.hlda = 1'b1;
    tick();
    check("rst pre grantCh", 32'(bus.grantCh), 32'd2);
    #2 RESET = 1'b0;
    #1;
    check("rst async hrq", 32'(bus.hrq), 32'd0);
    check("rst async grantValid", 32'(bus.grantValid), 32'd0);
    check("rst async dack", 32'(bus.dack), 32'hF);
    bus.hlda   = 1'b0;
    DREQ       = 4'b0000;
    commandReg = 8'h10;
    @(posedge CLK);
    #1 RESET = 1'b1;
    tick();
    check("rst release prioTop", 32'(prioTop), 32'd0);
    check("rst release hrq", 32'(bus.hrq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
